gauss_conv2d_sym: RTL

Parametrised symmetric 2D Gaussian convolver for the SIFT scale-space pipeline. It sits between the line-buffer window generator and the DoG subtractor. It folds a K×K pixel window by horizontal and vertical symmetry, multiplies the folded sums by a runtime-loadable quadrant of coefficients, and reduces the products in a pipelined adder tree. Unlike the fixed 11×11 convolver it has valid tracking per sample, a double-buffered coefficient bank, round/shift normalisation and output saturation.

---
 rtl/gauss_conv2d_sym.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gauss_conv2d_sym.sv
// gauss_conv2d_sym
// Symmetric K x K Gaussian convolver for the SIFT scale-space pipeline.
// The window is folded horizontally (F1) and then vertically (F2). The
// H x H folded sums are multiplied by the active coefficient quadrant (M).
// The products are reduced in a registered binary adder tree of T levels.
// The result is then rounded, shifted and saturated (N).
// Latency from in_valid to out_valid is L = 4 + T cycles.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, active-low
//   in_valid     window on win is valid this cycle
//   win          K*K pixels, row-major, pixel (r,c) at [(r*K+c)*DW +: DW]
//   coef_we      write coef_data into shadow[coef_addr] (addr >= H*H ignored)
//   coef_addr    shadow index i*H+j (i = row fold, j = column fold)
//   coef_data    coefficient value
//   coef_commit  copy the shadow bank into the active bank
//   dout         normalised, saturated convolution result
//   out_valid    dout belongs to an accepted window
//   sat          dout was clipped for this sample
module gauss_conv2d_sym #(
  parameter int K     = 11,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int SHIFT = 8,
  parameter int OW    = 18
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  input  logic [K*K*DW-1:0]                            win,
  input  logic                                         coef_we,
  input  logic [$clog2(((K+1)/2)*((K+1)/2))-1:0]       coef_addr,
  input  logic [CW-1:0]                                coef_data,
  input  logic                                         coef_commit,
  output logic [OW-1:0]                                dout,
  output logic                                         out_valid,
  output logic                                         sat
);

  localparam int H  = (K + 1) / 2;
  localparam int NP = H * H;
  localparam int T  = $clog2(NP);
  localparam int L  = 4 + T;
  localparam int PW = DW + 2 + CW;
  localparam int SW = PW + T;
  localparam int MW = (SW > SHIFT) ? SW : SHIFT;
  localparam int YW = (MW + 1 > OW + 1) ? MW + 1 : OW + 1;
  localparam logic [YW-1:0] RND =
    (SHIFT > 0) ? (YW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  // Number of live elements at a given adder-tree level.
  function automatic int lvl_cnt(input int l);
    int n;
    n = NP;
    for (int i = 0; i < l; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic [CW-1:0] shadow [NP];
  logic [CW-1:0] snap1  [NP];
  logic [CW-1:0] snap2  [NP];
  logic [CW-1:0] act    [NP];
  logic          c1;
  logic          c2;
  logic [L-1:0]  vld;

  logic [DW:0]   h  [K][H];
  logic [DW+1:0] s  [H][H];
  logic [SW-1:0] lv [T+1][NP];
  logic [YW-1:0] y;

  // The commit snapshot travels down a two-deep pipe together with the
  // delayed strobe. act changes exactly when the first window accepted after
  // the commit reaches the multiplier. Back-to-back commits each carry their
  // own snapshot. snap1 samples shadow before a same-cycle write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '{default: '0};
      snap1  <= '{default: '0};
      snap2  <= '{default: '0};
      act    <= '{default: '0};
      c1     <= 1'b0;
      c2     <= 1'b0;
    end else begin
      if (coef_we && (32'(coef_addr) < NP)) shadow[coef_addr] <= coef_data;
      if (coef_commit) snap1 <= shadow;
      if (c1) snap2 <= snap1;
      if (c2) act <= snap2;
      c1 <= coef_commit;
      c2 <= c1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld <= '0;
    else      vld <= {vld[L-2:0], in_valid};
  end

  assign out_valid = vld[L-1];

  always_ff @(posedge clk) begin
    for (int r = 0; r < K; r++) begin
      for (int j = 0; j < H; j++) begin
        if (j < H - 1)
          h[r][j] <= {1'b0, win[(r*K+j)*DW +: DW]} + {1'b0, win[(r*K+K-1-j)*DW +: DW]};
        else
          h[r][j] <= {1'b0, win[(r*K+j)*DW +: DW]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < H; i++) begin
      for (int j = 0; j < H; j++) begin
        if (i < H - 1) s[i][j] <= {1'b0, h[i][j]} + {1'b0, h[K-1-i][j]};
        else           s[i][j] <= {1'b0, h[i][j]};
      end
    end
  end

  // Level 0 holds the products. Each later level pairs neighbours, and an
  // unpaired last element is registered through unchanged. Slots beyond the
  // live count are held at zero. The modulo keeps the index in range.
  always_ff @(posedge clk) begin
    for (int i = 0; i < H; i++) begin
      for (int j = 0; j < H; j++) begin
        lv[0][i*H+j] <= SW'(PW'(s[i][j]) * PW'(act[i*H+j]));
      end
    end
    for (int l = 1; l <= T; l++) begin
      for (int e = 0; e < NP; e++) begin
        if (2 * e + 1 < lvl_cnt(l - 1))
          lv[l][e] <= lv[l-1][(2*e) % NP] + lv[l-1][(2*e+1) % NP];
        else if (2 * e < lvl_cnt(l - 1))
          lv[l][e] <= lv[l-1][(2*e) % NP];
        else
          lv[l][e] <= '0;
      end
    end
  end

  // The rounding add is done one bit wider than the tree sum, so the
  // carry cannot be lost before the shift.
  always_comb begin
    y = (YW'(lv[T][0]) + RND) >> SHIFT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if ((y >> OW) != '0) begin
      dout <= '1;
      sat  <= 1'b1;
    end else begin
      dout <= y[OW-1:0];
      sat  <= 1'b0;
    end
  end

endmodule
